// File: rtl/rot_pkg.sv
// Shared types and helpers for rot_issue_queue.
// Optional feature: ROT_LEFT_EN adds a per-request left-rotate flag.
package rot_pkg;

   localparam int ROT_DW = 8;
   localparam int ROT_AW = $clog2(ROT_DW);

   typedef struct packed {
      logic [ROT_DW-1:0] data;
      logic [ROT_AW-1:0] amt;
`ifdef ROT_LEFT_EN
      logic              left;
`endif
   } rot_req_t;

   // A left rotate by n is a right rotate by (dw - n) mod dw.
   function automatic int unsigned to_right_amt(input int unsigned amt, input logic left,
                                                input int unsigned dw = ROT_DW);
      return left ? (dw - amt) % dw : amt;
   endfunction

endpackage

// File: rtl/rot_req_fifo.sv
// Request FIFO for rot_issue_queue: storage, wrapping pointers and occupancy.
// Optional feature ROT_LEFT_EN only widens the entry, which is handled by the caller.
module rot_req_fifo
   import rot_pkg::*;
#(
   parameter  int EW    = ROT_DW + ROT_AW,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [EW-1:0] wdata,
   output logic [EW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [PW:0]   level
);

   logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
   logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]              cnt_q, cnt_d;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap for free.
         if (push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
         end
         if (pop) rptr_d = rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign rdata = mem_q[rptr_q];
   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign level = cnt_q;

endmodule

// File: rtl/rot_issue_queue.sv
// Buffers rotate requests and issues one per cycle from a registered slot to a right-rotator.
// Optional feature: ROT_LEFT_EN adds in_left; left amounts are converted to right amounts on load.
module rot_issue_queue
   import rot_pkg::*;
#(
   parameter  int DW    = ROT_DW,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DW),
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [AW-1:0] in_amt,
`ifdef ROT_LEFT_EN
   input  logic          in_left,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] sh_a,
   output logic [AW-1:0] sh_amt,
   output logic [LW-1:0] level
);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] amt;
`ifdef ROT_LEFT_EN
      logic          left;
`endif
   } req_t;

   req_t          wreq, head;
   logic          full, empty, push, pop, load, head_left;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] sh_a_q, sh_a_d;
   logic [AW-1:0] sh_amt_q, sh_amt_d;

   assign wreq.data = in_data;
   assign wreq.amt  = in_amt;
`ifdef ROT_LEFT_EN
   assign wreq.left = in_left;
   assign head_left = head.left;
`else
   assign head_left = 1'b0;
`endif

   // Ready depends on the registered count only, so producers never see a loop through out_ready.
   assign in_ready = ~full;
   assign push     = in_valid & in_ready & ~flush;
   assign load     = ~empty & (~out_valid_q | out_ready);
   assign pop      = load & ~flush;

   rot_req_fifo #(
      .EW   ($bits(req_t)),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .push (push),
      .pop  (pop),
      .wdata(wreq),
      .rdata(head),
      .full (full),
      .empty(empty),
      .level(level)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      sh_a_d      = sh_a_q;
      sh_amt_d    = sh_amt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (load) begin
         out_valid_d = 1'b1;
         sh_a_d      = head.data;
         sh_amt_d    = AW'(to_right_amt(32'(head.amt), head_left, DW));
      end else if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sh_a_q      <= '0;
         sh_amt_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         sh_a_q      <= sh_a_d;
         sh_amt_q    <= sh_amt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sh_a      = sh_a_q;
   assign sh_amt    = sh_amt_q;

endmodule

// File: tb/tb_rot_issue_queue.sv
// Bench for rot_issue_queue: queue-level reference model checked every cycle plus directed literals.
// Exercises the ROT_LEFT_EN conversion when that macro is defined.
module tb_rot_issue_queue;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic [2:0] in_amt = '0;
   logic       in_left = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] sh_a;
   logic [2:0] sh_amt;
   logic [2:0] level;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   rot_issue_queue #(.DW(8), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_amt   (in_amt),
`ifdef ROT_LEFT_EN
      .in_left  (in_left),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sh_a     (sh_a),
      .sh_amt   (sh_amt),
      .level    (level)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] rotr(input logic [7:0] a, input int n);
      logic [15:0] w;
      w = {a, a} >> n;
      return w[7:0];
   endfunction

   function automatic logic [2:0] exp_amt(input logic [2:0] a, input logic l);
`ifdef ROT_LEFT_EN
      int r;
      r = l ? (8 - int'(a)) % 8 : int'(a);
      return 3'(r);
`else
      if (l) return a;
      return a;
`endif
   endfunction

   // Reference model: a queue of pending requests plus one issue slot.
   typedef struct {
      logic [7:0] d;
      logic [2:0] ramt;
   } mreq_t;
   mreq_t      mq[$];
   bit         m_ov = 1'b0;
   logic [7:0] m_a = '0;
   logic [2:0] m_amt = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_ov  = 1'b0;
         m_a   = '0;
         m_amt = '0;
      end else begin
         cyc++;
         if (flush) begin
            mq.delete();
            m_ov = 1'b0;
         end else begin : upd
            bit    acc, ld;
            mreq_t nr;
            acc = in_valid && (mq.size() < DEPTH);
            ld  = (mq.size() > 0) && (!m_ov || out_ready);
            if (ld) begin
               m_a   = mq[0].d;
               m_amt = mq[0].ramt;
               mq.delete(0);
               m_ov  = 1'b1;
            end else if (m_ov && out_ready) begin
               m_ov = 1'b0;
            end
            if (acc) begin
               nr.d    = in_data;
               nr.ramt = exp_amt(in_amt, in_left);
               mq.push_back(nr);
            end
         end
      end
   end

   // Per-cycle compare against the model, plus an issue log for order/throughput checks.
   logic [7:0] issued[$];
   int         iss_cyc[$];
   int         max_lvl = 0;

   always @(negedge clk) begin
      if (!rst) begin
         check("out_valid", 32'(out_valid), 32'(m_ov));
         check("level", 32'(level), 32'(mq.size()));
         check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
         check("sh_a", 32'(sh_a), 32'(m_a));
         check("sh_amt", 32'(sh_amt), 32'(m_amt));
         if (int'(level) > max_lvl) max_lvl = int'(level);
         if (out_valid && out_ready) begin
            issued.push_back(sh_a);
            iss_cyc.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [7:0] d, input logic [2:0] a, input logic l);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_left  = l;
      while (!in_ready && t < 50) begin
         step();
         t++;
      end
      if (t >= 50) check("push_timeout", 32'(1), 32'(0));
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [7:0] exp3[6];

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step();
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_level", 32'(level), 32'(0));
      check("rst_sh_a", 32'(sh_a), 32'(0));
      check("rst_sh_amt", 32'(sh_amt), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));

      // Latency 2 into an empty queue
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      in_amt    = 3'd3;
      in_left   = 1'b0;
      step();
      in_valid = 1'b0;
      check("lat_n1_valid", 32'(out_valid), 32'(0));
      check("lat_n1_level", 32'(level), 32'(1));
      step();
      check("lat_n2_valid", 32'(out_valid), 32'(1));
      check("lat_sh_a", 32'(sh_a), 32'(8'hA5));
      check("lat_sh_amt", 32'(sh_amt), 32'(3));
      check("lat_y", 32'(rotr(sh_a, int'(sh_amt))), 32'(8'hB4));
      repeat (3) step();

      // Fill and backpressure
      out_ready = 1'b0;
      base = issued.size();
      for (int i = 0; i < 5; i++) push_req(8'h31 + 8'(i), 3'(i), 1'b0);
      check("fill_level", 32'(level), 32'(4));
      check("fill_in_ready", 32'(in_ready), 32'(0));
      check("fill_slot", 32'(sh_a), 32'(8'h31));
      in_valid = 1'b1;
      in_data  = 8'h36;
      in_amt   = 3'd5;
      repeat (2) step();
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_level", 32'(level), 32'(4));
      out_ready = 1'b1;
      step();
      check("bp_pop_ready", 32'(in_ready), 32'(1));
      check("bp_pop_level", 32'(level), 32'(3));
      step();
      in_valid = 1'b0;
      repeat (8) step();
      exp3 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
      check("bp_count", 32'(issued.size() - base), 32'(6));
      for (int i = 0; i < 6; i++)
         if (base + i < issued.size()) check("bp_order", 32'(issued[base+i]), 32'(exp3[i]));

      // Streaming 16 back-to-back
      base    = issued.size();
      max_lvl = 0;
      for (int i = 0; i < 16; i++) push_req(8'hC0 + 8'(i), 3'(i % 8), 1'b0);
      repeat (4) step();
      check("str_count", 32'(issued.size() - base), 32'(16));
      if (issued.size() - base == 16) begin
         check("str_consecutive", 32'(iss_cyc[base+15] - iss_cyc[base]), 32'(15));
         for (int i = 0; i < 16; i++)
            check("str_order", 32'(issued[base+i]), 32'(8'hC0 + 8'(i)));
      end
      check("str_max_level", 32'(max_lvl <= 1), 32'(1));

      // Flush while holding two entries and a valid slot
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_req(8'h51 + 8'(i), 3'd1, 1'b0);
      check("fl_pre_level", 32'(level), 32'(2));
      check("fl_pre_valid", 32'(out_valid), 32'(1));
      base     = issued.size();
      in_valid = 1'b1;
      in_data  = 8'h5F;
      flush    = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      check("fl_level", 32'(level), 32'(0));
      check("fl_valid", 32'(out_valid), 32'(0));
      out_ready = 1'b1;
      repeat (4) step();
      check("fl_no_issue", 32'(issued.size() - base), 32'(0));
      push_req(8'h60, 3'd2, 1'b0);
      repeat (3) step();
      check("fl_recover", 32'(issued.size() - base), 32'(1));

`ifdef ROT_LEFT_EN
      // Left rotate conversion
      push_req(8'h81, 3'd1, 1'b1);
      step();
      check("left1_amt", 32'(sh_amt), 32'(7));
      check("left1_y", 32'(rotr(sh_a, int'(sh_amt))), 32'(8'h03));
      repeat (2) step();
      push_req(8'h81, 3'd0, 1'b1);
      step();
      check("left0_amt", 32'(sh_amt), 32'(0));
      check("left0_y", 32'(rotr(sh_a, int'(sh_amt))), 32'(8'h81));
      repeat (2) step();
`endif

      // Reset mid-burst with three queued and one in the slot
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_req(8'h11 + 8'(i), 3'(i), 1'b0);
      check("mr_pre_level", 32'(level), 32'(3));
      in_valid = 1'b1;
      in_data  = 8'h15;
      #2 rst = 1'b1;
      #1;
      check("mr_level", 32'(level), 32'(0));
      check("mr_valid", 32'(out_valid), 32'(0));
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("mr_in_ready", 32'(in_ready), 32'(1));
      check("mr_level_after", 32'(level), 32'(0));
      out_ready = 1'b1;
      base = issued.size();
      repeat (3) step();
      check("mr_no_issue", 32'(issued.size() - base), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
